// File: rtl/tpu_seq_ctrl_if.sv
// Host command channel for the micro-TPU sequencer: one beat per cmd_valid && cmd_ready.
interface tpu_seq_ctrl_if #(
    parameter int unsigned DW = 8
);
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [DW-1:0] din;
    logic          cmd_ready;

    modport master (output cmd_valid, cmd_op, din, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, din, output cmd_ready);
endinterface

// File: rtl/tpu_seq_ctrl.sv
// Command sequencer for the NxN systolic MAC array: buffer loads, clear/step pulses, result reads.
// Optional feature: define TPU_SEQ_AUTO_DRAIN_EN to stream all results out after each RUN.
module tpu_seq_ctrl #(
    parameter  int unsigned N  = 2,
    parameter  int unsigned DW = 8,
    localparam int unsigned AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    tpu_seq_ctrl_if.slave cmd,
    output logic          w_we,
    output logic          a_we,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_wdata,
    output logic          arr_clr,
    output logic          arr_en,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int unsigned NN    = N * N;
    localparam int unsigned STEPS = 3 * N - 1;
    localparam int unsigned SW    = $clog2(STEPS + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NN - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS);

    localparam logic [1:0] OP_LOAD_W = 2'd0;
    localparam logic [1:0] OP_LOAD_A = 2'd1;
    localparam logic [1:0] OP_RUN    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_A,
        S_CLR,
        S_STEP,
`ifdef TPU_SEQ_AUTO_DRAIN_EN
        S_FIN,
        S_DRAIN
`else
        S_FIN
`endif
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] rd_ptr;
    logic [SW-1:0] step_cnt;
    logic          w_loaded;
    logic          a_loaded;
    logic          accept;

    // Ready is combinational so a frozen (ena=0) sequencer never completes a handshake.
    assign cmd.cmd_ready = ena && (state == S_IDLE || state == S_LOAD_W || state == S_LOAD_A);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rd_ptr    <= '0;
            step_cnt  <= '0;
            w_loaded  <= 1'b0;
            a_loaded  <= 1'b0;
            w_we      <= 1'b0;
            a_we      <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            arr_clr   <= 1'b0;
            arr_en    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            w_we     <= 1'b0;
            a_we     <= 1'b0;
            arr_clr  <= 1'b0;
            arr_en   <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            // Frozen: strobes drop, state and counters hold.
            if (ena) begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            case (cmd.cmd_op)
                                OP_LOAD_W: begin
                                    state  <= S_LOAD_W;
                                    cnt    <= '0;
                                    rd_ptr <= '0;
                                end
                                OP_LOAD_A: begin
                                    state  <= S_LOAD_A;
                                    cnt    <= '0;
                                    rd_ptr <= '0;
                                end
                                OP_RUN: begin
                                    rd_ptr <= '0;
                                    if (w_loaded && a_loaded) begin
                                        state   <= S_CLR;
                                        arr_clr <= 1'b1;
                                        busy    <= 1'b1;
                                    end else begin
                                        err <= 1'b1;
                                    end
                                end
                                default: begin
                                    rd_valid <= 1'b1;
                                    rd_addr  <= rd_ptr;
                                    rd_ptr   <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AW'(1);
                                end
                            endcase
                        end
                    end
                    S_LOAD_W, S_LOAD_A: begin
                        if (accept) begin
                            w_we      <= (state == S_LOAD_W);
                            a_we      <= (state == S_LOAD_A);
                            buf_addr  <= cnt;
                            buf_wdata <= cmd.din;
                            if (cnt == LAST_ADDR) begin
                                state <= S_IDLE;
                                if (state == S_LOAD_W) w_loaded <= 1'b1;
                                else                   a_loaded <= 1'b1;
                            end else begin
                                cnt <= cnt + AW'(1);
                            end
                        end
                    end
                    S_CLR: begin
                        state    <= S_STEP;
                        arr_en   <= 1'b1;
                        step_cnt <= SW'(1);
                    end
                    // step_cnt counts pulses issued, so an ena pause never loses a step.
                    S_STEP: begin
                        if (step_cnt == LAST_STEP) begin
`ifdef TPU_SEQ_AUTO_DRAIN_EN
                            state    <= S_DRAIN;
                            rd_valid <= 1'b1;
                            rd_addr  <= '0;
`else
                            state <= S_FIN;
                            done  <= 1'b1;
`endif
                        end else begin
                            arr_en   <= 1'b1;
                            step_cnt <= step_cnt + SW'(1);
                        end
                    end
`ifdef TPU_SEQ_AUTO_DRAIN_EN
                    S_DRAIN: begin
                        if (rd_addr == LAST_ADDR) begin
                            state  <= S_FIN;
                            done   <= 1'b1;
                            rd_ptr <= '0;
                        end else begin
                            rd_valid <= 1'b1;
                            rd_addr  <= rd_addr + AW'(1);
                        end
                    end
`endif
                    S_FIN: begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        a_loaded <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl: stimulus queues expected strobes, a negedge monitor checks them.
module tb_tpu_seq_ctrl;
    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    localparam int K_EN   = 3;
    localparam int K_CLR  = 2;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;
    localparam int K_RD   = 6;

    localparam logic [1:0] OP_LW  = 2'd0;
    localparam logic [1:0] OP_LA  = 2'd1;
    localparam logic [1:0] OP_RUN = 2'd2;
    localparam logic [1:0] OP_RD  = 2'd3;

`ifdef TPU_SEQ_AUTO_DRAIN_EN
    localparam int DONE_OFF = 10;
`else
    localparam int DONE_OFF = 6;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          w_we, a_we, arr_clr, arr_en, rd_valid, busy, done, err;
    logic [AW-1:0] buf_addr, rd_addr;
    logic [DW-1:0] buf_wdata;

    tpu_seq_ctrl_if #(.DW(DW)) cmd ();

    tpu_seq_ctrl #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .cmd      (cmd),
        .w_we     (w_we),
        .a_we     (a_we),
        .buf_addr (buf_addr),
        .buf_wdata(buf_wdata),
        .arr_clr  (arr_clr),
        .arr_en   (arr_en),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int edge_n;
        int addr;
        int data;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push(input int kind, input int e, input int a, input int d);
        ev_t ev;
        ev.kind = kind; ev.edge_n = e; ev.addr = a; ev.data = d;
        exp_q.push_back(ev);
    endfunction

    function automatic void obs(input int kind, input int a, input int d);
        ev_t ev;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: kind %0d at edge %0d, expected none", kind, cyc);
        end else begin
            ev = exp_q.pop_front();
            check("ev_kind", kind, ev.kind);
            check("ev_edge", cyc, ev.edge_n);
            check("ev_addr", a, ev.addr);
            check("ev_data", d, ev.data);
        end
    endfunction

    // Monitor: every visible strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (w_we === 1'b1)     obs(0, int'(buf_addr), int'(buf_wdata));
        if (a_we === 1'b1)     obs(1, int'(buf_addr), int'(buf_wdata));
        if (arr_clr === 1'b1)  obs(K_CLR, 0, 0);
        if (arr_en === 1'b1)   obs(K_EN, 0, 0);
        if (done === 1'b1)     obs(K_DONE, 0, 0);
        if (err === 1'b1)      obs(K_ERR, 0, 0);
        if (rd_valid === 1'b1) obs(K_RD, int'(rd_addr), 0);
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d, output int e);
        @(negedge clk);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.din       = d;
        check("cmd_ready_at_send", int'(cmd.cmd_ready), 1);
        @(posedge clk);
        #1 e = cyc;
    endtask

    task automatic idle(input int n);
        cmd.cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Loads bytes 0x11*(first+i); op doubles as the expected strobe kind.
    task automatic load(input logic [1:0] op, input int first, input bit gap);
        int e;
        logic [7:0] d;
        send(op, 8'h00, e);
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h11 * (first + i));
            send(2'd0, d, e);
            push(int'(op), e, i, int'(d));
            if (gap && i == 1) idle(2);
        end
        idle(1);
    endtask

    initial begin
        int k, e, done_cnt;
        int rd_exp[5];
        rd_exp = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        ena   = 1'b1;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'd0;
        cmd.din       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_arr_en", int'(arr_en), 0);
        check("rst_w_we", int'(w_we), 0);
        check("rst_cmd_ready", int'(cmd.cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // RUN with nothing loaded
        send(OP_RUN, 8'h00, e);
        push(K_ERR, e, 0, 0);
        idle(1);

        // LOAD_W with a 2-cycle gap after the second byte
        load(OP_LW, 1, 1'b1);

        // RUN with weights only
        send(OP_RUN, 8'h00, e);
        push(K_ERR, e, 0, 0);
        idle(1);

        load(OP_LA, 5, 1'b0);

        // Full RUN; busy and !cmd_ready through the done cycle
        send(OP_RUN, 8'h00, k);
        cmd.cmd_valid = 1'b0;
        push(K_CLR, k, 0, 0);
        for (int i = 1; i <= 5; i++) push(K_EN, k + i, 0, 0);
`ifdef TPU_SEQ_AUTO_DRAIN_EN
        for (int i = 0; i < 4; i++) push(K_RD, k + 6 + i, i, 0);
`endif
        push(K_DONE, k + DONE_OFF, 0, 0);
        for (int i = 0; i <= DONE_OFF; i++) begin
            @(negedge clk);
            check("run_busy", int'(busy), 1);
            check("run_cmd_ready", int'(cmd.cmd_ready), 0);
        end
        @(negedge clk);
        check("post_run_busy", int'(busy), 0);
        check("post_run_cmd_ready", int'(cmd.cmd_ready), 1);

        // Back-to-back READs wrap after N*N
        for (int i = 0; i < 5; i++) begin
            send(OP_RD, 8'h00, e);
            push(K_RD, e, rd_exp[i], 0);
        end
        idle(1);

        // Activations consumed by the RUN
        send(OP_RUN, 8'h00, e);
        push(K_ERR, e, 0, 0);
        idle(1);

        // RUN with ena low for 3 edges mid-STEP
        load(OP_LA, 9, 1'b0);
        send(OP_RUN, 8'h00, k);
        cmd.cmd_valid = 1'b0;
        push(K_CLR, k, 0, 0);
        push(K_EN, k + 1, 0, 0);
        push(K_EN, k + 2, 0, 0);
        for (int i = 6; i <= 8; i++) push(K_EN, k + i, 0, 0);
`ifdef TPU_SEQ_AUTO_DRAIN_EN
        for (int i = 0; i < 4; i++) push(K_RD, k + 9 + i, i, 0);
        push(K_DONE, k + 13, 0, 0);
`else
        push(K_DONE, k + 9, 0, 0);
`endif
        repeat (3) @(negedge clk);
        ena = 1'b0;
        check("frozen_cmd_ready", int'(cmd.cmd_ready), 0);
        repeat (3) @(negedge clk);
        check("frozen_busy", int'(busy), 1);
        ena = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // Reset mid-STEP aborts the RUN
        load(OP_LA, 13, 1'b0);
        send(OP_RUN, 8'h00, k);
        cmd.cmd_valid = 1'b0;
        push(K_CLR, k, 0, 0);
        push(K_EN, k + 1, 0, 0);
        push(K_EN, k + 2, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_arr_en", int'(arr_en), 0);
        check("abort_cmd_ready", int'(cmd.cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_done_pulses", done_cnt, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
